gray_sobel_frame_sequencer: RTL and testbench

- Frame-level controller for the grayscale/Sobel datapath (top_gray_sobel).
- Latches a mode and frame size, then issues one start strobe per accepted input pixel, with select held constant for the frame.
- Counts pixels issued and returned, and buffers returned pixels in a small output FIFO.
- Credit-based flow control means the FIFO never overflows. Sits between the SPI pixel interface and the datapath.

---
 rtl/gray_sobel_frame_sequencer_if.sv | 47 ++++
 rtl/gray_sobel_frame_sequencer.sv | 115 +++++++++++
 tb/tb_gray_sobel_frame_sequencer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gray_sobel_frame_sequencer_if.sv
// Handshake and datapath signals between the frame sequencer and its environment.
// The sequencer uses the slave modport; the pixel source/sink and datapath side uses master.
interface gray_sobel_frame_sequencer_if #(
    parameter int MAX_PIXEL_BITS = 8,
    parameter int DIM_BITS       = 10
);
    logic                      frame_start_i;
    logic [1:0]                mode_i;
    logic [DIM_BITS-1:0]       width_i;
    logic [DIM_BITS-1:0]       height_i;
    logic                      px_in_valid_i;
    logic [MAX_PIXEL_BITS-1:0] px_in_data_i;
    logic                      px_in_ready_o;
    logic [1:0]                dp_select_o;
    logic                      dp_start_o;
    logic [MAX_PIXEL_BITS-1:0] dp_pixel_o;
    logic                      dp_px_ready_i;
    logic [MAX_PIXEL_BITS-1:0] dp_pixel_i;
    logic                      px_out_valid_o;
    logic [MAX_PIXEL_BITS-1:0] px_out_data_o;
    logic                      px_out_ready_i;
    logic                      busy_o;
    logic                      frame_done_o;
    logic                      timeout_o;

    modport slave (
        input  frame_start_i, mode_i, width_i, height_i,
        input  px_in_valid_i, px_in_data_i,
        output px_in_ready_o,
        output dp_select_o, dp_start_o, dp_pixel_o,
        input  dp_px_ready_i, dp_pixel_i,
        output px_out_valid_o, px_out_data_o,
        input  px_out_ready_i,
        output busy_o, frame_done_o, timeout_o
    );

    modport master (
        output frame_start_i, mode_i, width_i, height_i,
        output px_in_valid_i, px_in_data_i,
        input  px_in_ready_o,
        input  dp_select_o, dp_start_o, dp_pixel_o,
        output dp_px_ready_i, dp_pixel_i,
        input  px_out_valid_o, px_out_data_o,
        output px_out_ready_i,
        input  busy_o, frame_done_o, timeout_o
    );
endinterface

// File: rtl/gray_sobel_frame_sequencer.sv
// Frame-level sequencer for the grayscale/Sobel datapath: issues one start per accepted
// pixel, collects returns into a small FIFO, and limits in-flight work with FIFO credits.
module gray_sobel_frame_sequencer #(
    parameter int MAX_PIXEL_BITS = 8,
    parameter int DIM_BITS       = 10,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input logic                         clk_i,
    input logic                         reset_i,
    gray_sobel_frame_sequencer_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = 2 * DIM_BITS;
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]                state, state_nxt;
    logic [1:0]                mode_q;
    logic [CW-1:0]             total_q, issued_q, returned_q, total_new;
    logic [IW-1:0]             idle_q;
    logic                      timeout_q, frame_done_q, timeout_set;
    logic                      vld_p1;
    logic [MAX_PIXEL_BITS-1:0] pixel_p1;
    logic [MAX_PIXEL_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]             wr_ptr, rd_ptr;
    logic [AW:0]               count;
    logic [CW:0]               credits_used;
    logic                      can_issue, accept, push, pop, start_ok;

    assign total_new    = CW'(bus.width_i) * CW'(bus.height_i);
    // In-flight pixels plus buffered pixels must never exceed what the FIFO can absorb.
    assign credits_used = {1'b0, issued_q - returned_q} + (CW + 1)'(count);
    assign can_issue    = (state == S_RUN) && (issued_q < total_q) &&
                          (credits_used < (CW + 1)'(FIFO_DEPTH));
    assign accept       = bus.px_in_valid_i && can_issue;
    assign push         = (state != S_IDLE) && bus.dp_px_ready_i && (returned_q < total_q);
    assign pop          = (count != '0) && bus.px_out_ready_i;
    assign start_ok     = (state == S_IDLE) && bus.frame_start_i;
    assign timeout_set  = (state == S_DRAIN) && (returned_q != total_q) &&
                          (idle_q == IW'(TIMEOUT_CYCLES));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.frame_start_i) state_nxt = (total_new == '0) ? S_DONE : S_RUN;
            S_RUN:   if (issued_q == total_q) state_nxt = S_DRAIN;
            S_DRAIN: if (returned_q == total_q || timeout_set) state_nxt = S_DONE;
            S_DONE:  if (count == '0 && !push) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state        <= S_IDLE;
            mode_q       <= 2'b00;
            total_q      <= '0;
            issued_q     <= '0;
            returned_q   <= '0;
            idle_q       <= '0;
            timeout_q    <= 1'b0;
            frame_done_q <= 1'b0;
            vld_p1       <= 1'b0;
            pixel_p1     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
        end else begin
            state        <= state_nxt;
            frame_done_q <= (state_nxt == S_DONE) && (state != S_DONE);
            // p1: registered start strobe and pixel toward the datapath
            vld_p1       <= accept;
            if (accept) begin
                pixel_p1 <= bus.px_in_data_i;
                issued_q <= issued_q + CW'(1);
            end
            if (push) begin
                returned_q <= returned_q + CW'(1);
                wr_ptr     <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
            if (state == S_DRAIN) idle_q <= bus.dp_px_ready_i ? '0 : idle_q + IW'(1);
            if (timeout_set) timeout_q <= 1'b1;
            if (start_ok) begin
                mode_q     <= bus.mode_i;
                total_q    <= total_new;
                issued_q   <= '0;
                returned_q <= '0;
                idle_q     <= '0;
                timeout_q  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr] <= bus.dp_pixel_i;
    end

    assign bus.px_in_ready_o  = can_issue;
    assign bus.dp_select_o    = mode_q;
    assign bus.dp_start_o     = vld_p1;
    assign bus.dp_pixel_o     = pixel_p1;
    assign bus.px_out_valid_o = (count != '0);
    // Head is masked while empty so stale storage never leaks onto the output bus.
    assign bus.px_out_data_o  = (count != '0) ? fifo_mem[rd_ptr] : '0;
    assign bus.busy_o         = (state != S_IDLE);
    assign bus.frame_done_o   = frame_done_q;
    assign bus.timeout_o      = timeout_q;
endmodule

// File: tb/tb_gray_sobel_frame_sequencer.sv
// Directed bench for the frame sequencer: a 3-cycle inverting datapath model plus an
// expected-output queue filled on pixel accept and drained on output pops.
module tb_gray_sobel_frame_sequencer;
    localparam int PW    = 8;
    localparam int DW    = 10;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gray_sobel_frame_sequencer_if #(.MAX_PIXEL_BITS(PW), .DIM_BITS(DW)) bus ();

    gray_sobel_frame_sequencer #(
        .MAX_PIXEL_BITS(PW), .DIM_BITS(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(1023)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .bus    (bus)
    );

    int n_pass = 0, n_total = 0;
    int start_cnt = 0, done_cnt = 0, out_cnt = 0, sel_err = 0, occ_viol = 0;
    int drop_at = -1;
    int px_seed = 0;
    logic [1:0]    exp_mode = 2'b00;
    logic          prev_acc = 1'b0;
    logic [PW-1:0] prev_data = '0;
    logic [PW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Datapath model: inverted pixel returned three cycles after each start.
    logic          m_v0 = 1'b0, m_v1 = 1'b0, m_v2 = 1'b0;
    logic [PW-1:0] m_d0 = '0, m_d1 = '0, m_d2 = '0;
    always @(posedge clk) begin
        m_v0 <= bus.dp_start_o && (start_cnt != drop_at);
        m_d0 <= ~bus.dp_pixel_o;
        m_v1 <= m_v0;
        m_d1 <= m_d0;
        m_v2 <= m_v1;
        m_d2 <= m_d1;
    end
    assign bus.dp_px_ready_i = m_v2;
    assign bus.dp_pixel_i    = m_d2;

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_acc) begin
                chk("dp_start_latency", bus.dp_start_o, 1);
                chk("dp_pixel", bus.dp_pixel_o, prev_data);
            end
            if (bus.dp_start_o) begin
                start_cnt++;
                if (bus.dp_select_o !== exp_mode) sel_err++;
            end
            if (bus.frame_done_o) done_cnt++;
            if (bus.px_out_valid_o && bus.px_out_ready_i) begin
                out_cnt++;
                chk("px_out_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("px_out_data", bus.px_out_data_o, exp_q.pop_front());
            end
            prev_acc  = bus.px_in_valid_i && bus.px_in_ready_o;
            prev_data = bus.px_in_data_i;
            if (prev_acc) exp_q.push_back(~bus.px_in_data_i);
            if (exp_q.size() > DEPTH) occ_viol++;
        end else begin
            prev_acc = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [1:0] m, input int w, input int h);
        bus.mode_i        = m;
        bus.width_i       = w[DW-1:0];
        bus.height_i      = h[DW-1:0];
        bus.frame_start_i = 1'b1;
        tick();
        bus.frame_start_i = 1'b0;
    endtask

    task automatic next_px();
        px_seed++;
        bus.px_in_data_i = PW'(px_seed * 53 + 7);
    endtask

    task automatic stream(input int n, input int limit, output int sent);
        int cyc = 0;
        sent = 0;
        next_px();
        bus.px_in_valid_i = (n > 0);
        while (sent < n && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (bus.px_in_ready_o) begin
                sent++;
                tick();
                next_px();
            end else begin
                tick();
            end
        end
        bus.px_in_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input string tag);
        int cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.busy_o && cyc < limit);
        chk(tag, bus.busy_o, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, bus.busy_o, 0);
        chk({tag, "_in_ready"}, bus.px_in_ready_o, 0);
        chk({tag, "_dp_start"}, bus.dp_start_o, 0);
        chk({tag, "_dp_select"}, bus.dp_select_o, 0);
        chk({tag, "_dp_pixel"}, bus.dp_pixel_o, 0);
        chk({tag, "_out_valid"}, bus.px_out_valid_o, 0);
        chk({tag, "_out_data"}, bus.px_out_data_o, 0);
        chk({tag, "_frame_done"}, bus.frame_done_o, 0);
        chk({tag, "_timeout"}, bus.timeout_o, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, d0, o0, sent, sent2;
        rst = 1'b1;
        bus.frame_start_i  = 1'b0;
        bus.mode_i         = 2'b00;
        bus.width_i        = '0;
        bus.height_i       = '0;
        bus.px_in_valid_i  = 1'b0;
        bus.px_in_data_i   = '0;
        bus.px_out_ready_i = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // 2x2 frame, mode 01, sink always ready
        tick();
        s0 = start_cnt; d0 = done_cnt; o0 = out_cnt;
        exp_mode = 2'b01;
        start_frame(2'b01, 2, 2);
        @(negedge clk);
        chk("t1_busy", bus.busy_o, 1);
        chk("t1_in_ready", bus.px_in_ready_o, 1);
        chk("t1_select", bus.dp_select_o, 2'b01);
        tick();
        stream(4, 40, sent);
        chk("t1_sent", sent, 4);
        wait_idle(60, "t1_idle");
        chk("t1_starts", start_cnt - s0, 4);
        chk("t1_outputs", out_cnt - o0, 4);
        chk("t1_done", done_cnt - d0, 1);
        chk("t1_queue_empty", exp_q.size(), 0);
        chk("t1_select_err", sel_err, 0);

        // 4x4 frame with the sink stalled: credits stop input after FIFO_DEPTH accepts
        tick();
        s0 = start_cnt; d0 = done_cnt; o0 = out_cnt;
        exp_mode = 2'b10;
        bus.px_out_ready_i = 1'b0;
        start_frame(2'b10, 4, 4);
        stream(16, 30, sent);
        chk("t2_stalled_accepts", sent, DEPTH);
        @(negedge clk);
        chk("t2_in_ready_low", bus.px_in_ready_o, 0);
        chk("t2_out_valid", bus.px_out_valid_o, 1);
        tick();
        bus.px_out_ready_i = 1'b1;
        stream(16 - sent, 300, sent2);
        chk("t2_rest_sent", sent2, 16 - DEPTH);
        wait_idle(100, "t2_idle");
        chk("t2_starts", start_cnt - s0, 16);
        chk("t2_outputs", out_cnt - o0, 16);
        chk("t2_done", done_cnt - d0, 1);
        chk("t2_queue_empty", exp_q.size(), 0);

        // zero-width frame goes straight to DONE
        tick();
        s0 = start_cnt; d0 = done_cnt;
        start_frame(2'b11, 0, 5);
        @(negedge clk);
        chk("t3_busy", bus.busy_o, 1);
        chk("t3_frame_done", bus.frame_done_o, 1);
        chk("t3_in_ready", bus.px_in_ready_o, 0);
        wait_idle(20, "t3_idle");
        chk("t3_starts", start_cnt - s0, 0);
        chk("t3_done", done_cnt - d0, 1);

        // 1x3 frame with the last return dropped: DRAIN times out
        tick();
        s0 = start_cnt; d0 = done_cnt; o0 = out_cnt;
        exp_mode = 2'b01;
        drop_at = start_cnt + 3;
        start_frame(2'b01, 1, 3);
        stream(3, 40, sent);
        chk("t4_sent", sent, 3);
        wait_idle(1300, "t4_idle");
        chk("t4_timeout", bus.timeout_o, 1);
        chk("t4_starts", start_cnt - s0, 3);
        chk("t4_outputs", out_cnt - o0, 2);
        chk("t4_done", done_cnt - d0, 1);
        drop_at = -1;
        exp_q.delete();

        // frame_start during RUN and during DONE is ignored
        tick();
        s0 = start_cnt; d0 = done_cnt; o0 = out_cnt;
        exp_mode = 2'b10;
        bus.px_out_ready_i = 1'b0;
        start_frame(2'b10, 1, 2);
        @(negedge clk);
        chk("t6_timeout_cleared", bus.timeout_o, 0);
        tick();
        start_frame(2'b11, 5, 5);
        stream(2, 40, sent);
        chk("t6_sent", sent, 2);
        for (int i = 0; i < 40 && done_cnt == d0; i++) @(negedge clk);
        chk("t6_done_seen", done_cnt - d0, 1);
        tick();
        start_frame(2'b11, 3, 3);
        @(negedge clk);
        chk("t6_still_done", bus.busy_o, 1);
        chk("t6_select_held", bus.dp_select_o, 2'b10);
        tick();
        bus.px_out_ready_i = 1'b1;
        wait_idle(40, "t6_idle");
        repeat (3) @(negedge clk);
        chk("t6_stays_idle", bus.busy_o, 0);
        chk("t6_starts", start_cnt - s0, 2);
        chk("t6_outputs", out_cnt - o0, 2);
        chk("t6_done", done_cnt - d0, 1);
        chk("t6_select_err", sel_err, 0);

        // reset in the middle of an 8x8 frame, then a clean 1x1 frame
        tick();
        exp_mode = 2'b11;
        start_frame(2'b11, 8, 8);
        stream(10, 60, sent);
        chk("t5_sent", sent, 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("t5_reset");
        exp_q.delete();
        repeat (6) tick();
        s0 = start_cnt; d0 = done_cnt; o0 = out_cnt;
        exp_mode = 2'b01;
        start_frame(2'b01, 1, 1);
        stream(1, 20, sent);
        chk("t5b_sent", sent, 1);
        wait_idle(40, "t5b_idle");
        chk("t5b_starts", start_cnt - s0, 1);
        chk("t5b_outputs", out_cnt - o0, 1);
        chk("t5b_done", done_cnt - d0, 1);
        chk("t5b_queue_empty", exp_q.size(), 0);
        chk("occupancy_limit", occ_viol, 0);
        chk("select_err_total", sel_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
